// File: rtl/bp_io_merge_pkg.sv
// Shared types and sizing helpers for the BedRock I/O command merge slice.
package bp_io_merge_pkg;

   typedef enum logic [0:0] {
      e_cmd_idle = 1'b0,
      e_cmd_data = 1'b1
   } bp_io_cmd_state_e;

   typedef enum logic [0:0] {
      e_resp_idle = 1'b0,
      e_resp_data = 1'b1
   } bp_io_resp_state_e;

   // Index width that never collapses to zero bits (one source still needs a 1-bit id).
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Bits needed to hold the values 0..n inclusive.
   function automatic int width_of(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/bp_io_src_route_fifo.sv
// Route FIFO: remembers which source issued each in-flight command, oldest first.
module bp_io_src_route_fifo
   import bp_io_merge_pkg::*;
#(
   parameter int els_p   = 8,
   parameter int width_p = 2,
   localparam int ptr_width_lp   = safe_clog2(els_p),
   localparam int count_width_lp = width_of(els_p)
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic [width_p-1:0]        data_i,
   input  logic                      v_i,
   output logic [width_p-1:0]        data_o,
   input  logic                      yumi_i,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [count_width_lp-1:0] count_o
);

   logic [width_p-1:0]        mem_q [els_p];
   logic [ptr_width_lp-1:0]   wptr_q, rptr_q;
   logic [count_width_lp-1:0] count_q;
   logic                      push, pop;

   assign full_o  = (count_q == count_width_lp'(els_p));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rptr_q];
   assign push    = v_i & ~full_o;
   assign pop     = yumi_i & ~empty_o;

   // Storage needs no reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= data_i;
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/bp_io_cmd_merge.sv
// Merges per-core BedRock I/O command streams onto one link and routes responses back in order.
module bp_io_cmd_merge
   import bp_io_merge_pkg::*;
#(
   parameter int num_src_p         = 4,
   parameter int header_width_p    = 72,
   parameter int data_width_p      = 64,
   parameter int max_outstanding_p = 8,
   localparam int src_id_width_lp  = safe_clog2(num_src_p),
   localparam int out_width_lp     = width_of(max_outstanding_p)
) (
   input  logic                                     clk_i,
   input  logic                                     reset_n_i,

   input  logic [num_src_p-1:0][header_width_p-1:0] src_cmd_header_i,
   input  logic [num_src_p-1:0]                     src_cmd_header_v_i,
   output logic [num_src_p-1:0]                     src_cmd_header_ready_and_o,
   input  logic [num_src_p-1:0]                     src_cmd_has_data_i,
   input  logic [num_src_p-1:0][data_width_p-1:0]   src_cmd_data_i,
   input  logic [num_src_p-1:0]                     src_cmd_data_v_i,
   output logic [num_src_p-1:0]                     src_cmd_data_ready_and_o,
   input  logic [num_src_p-1:0]                     src_cmd_last_i,

   output logic [header_width_p-1:0]                io_cmd_header_o,
   output logic                                     io_cmd_header_v_o,
   output logic                                     io_cmd_has_data_o,
   output logic [data_width_p-1:0]                  io_cmd_data_o,
   output logic                                     io_cmd_data_v_o,
   output logic                                     io_cmd_last_o,
   input  logic                                     io_cmd_header_ready_and_i,
   input  logic                                     io_cmd_data_ready_and_i,

   input  logic [header_width_p-1:0]                io_resp_header_i,
   input  logic                                     io_resp_header_v_i,
   input  logic                                     io_resp_has_data_i,
   input  logic [data_width_p-1:0]                  io_resp_data_i,
   input  logic                                     io_resp_data_v_i,
   input  logic                                     io_resp_last_i,
   output logic                                     io_resp_header_ready_and_o,
   output logic                                     io_resp_data_ready_and_o,

   output logic [num_src_p-1:0][header_width_p-1:0] src_resp_header_o,
   output logic [num_src_p-1:0]                     src_resp_header_v_o,
   output logic [num_src_p-1:0]                     src_resp_has_data_o,
   output logic [num_src_p-1:0][data_width_p-1:0]   src_resp_data_o,
   output logic [num_src_p-1:0]                     src_resp_data_v_o,
   output logic [num_src_p-1:0]                     src_resp_last_o,
   input  logic [num_src_p-1:0]                     src_resp_header_ready_and_i,
   input  logic [num_src_p-1:0]                     src_resp_data_ready_and_i,

   output logic [out_width_lp-1:0]                  outstanding_o
);

   bp_io_cmd_state_e           cmd_state_q, cmd_state_d;
   bp_io_resp_state_e          resp_state_q, resp_state_d;
   logic [src_id_width_lp-1:0] rr_q, rr_d;
   logic [src_id_width_lp-1:0] lock_q, lock_d;
   logic [src_id_width_lp-1:0] grant_id, cmd_sel, head_id;
   logic                       grant_v;
   logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic                       cmd_hdr_v, cmd_hdr_hs, cmd_data_active, cmd_data_hs;
   logic                       resp_hdr_open, resp_data_active, resp_hdr_hs, resp_data_hs;

   // Round-robin pick: first valid source at or after the pointer; ready never enters here.
   always_comb begin
      int idx;
      grant_v  = 1'b0;
      grant_id = '0;
      idx      = 0;
      for (int i = 0; i < num_src_p; i++) begin
         idx = (int'(rr_q) + i) % num_src_p;
         if (!grant_v && src_cmd_header_v_i[idx]) begin
            grant_v  = 1'b1;
            grant_id = idx[src_id_width_lp-1:0];
         end
      end
   end

   // Reset gating keeps every valid/ready low while reset is held, whatever the sources drive.
   assign cmd_hdr_v       = reset_n_i & (cmd_state_q == e_cmd_idle) & grant_v & ~fifo_full;
   assign cmd_hdr_hs      = cmd_hdr_v & io_cmd_header_ready_and_i;
   assign cmd_data_active = reset_n_i & (cmd_state_q == e_cmd_data);
   assign cmd_data_hs     = io_cmd_data_v_o & io_cmd_data_ready_and_i;
   assign cmd_sel         = (cmd_state_q == e_cmd_data) ? lock_q : grant_id;

   assign io_cmd_header_o   = src_cmd_header_i[cmd_sel];
   assign io_cmd_has_data_o = src_cmd_has_data_i[cmd_sel];
   assign io_cmd_data_o     = src_cmd_data_i[cmd_sel];
   assign io_cmd_last_o     = src_cmd_last_i[cmd_sel];
   assign io_cmd_header_v_o = cmd_hdr_v;
   assign io_cmd_data_v_o   = cmd_data_active & src_cmd_data_v_i[lock_q];

   // Only the granted (header) or locked (data) source ever sees ready.
   always_comb begin
      src_cmd_header_ready_and_o = '0;
      src_cmd_data_ready_and_o   = '0;
      if (cmd_hdr_v)       src_cmd_header_ready_and_o[grant_id] = io_cmd_header_ready_and_i;
      if (cmd_data_active) src_cmd_data_ready_and_o[lock_q]     = io_cmd_data_ready_and_i;
   end

   // Command FSM: advance pointer on each header, lock to the source for multi-beat messages.
   always_comb begin
      cmd_state_d = cmd_state_q;
      rr_d        = rr_q;
      lock_d      = lock_q;
      unique case (cmd_state_q)
         e_cmd_idle: begin
            if (cmd_hdr_hs) begin
               rr_d = (grant_id == src_id_width_lp'(num_src_p - 1)) ? '0 : grant_id + 1'b1;
               if (src_cmd_has_data_i[grant_id]) begin
                  cmd_state_d = e_cmd_data;
                  lock_d      = grant_id;
               end
            end
         end
         e_cmd_data: begin
            if (cmd_data_hs && src_cmd_last_i[lock_q]) cmd_state_d = e_cmd_idle;
         end
      endcase
   end

   assign resp_hdr_open    = reset_n_i & (resp_state_q == e_resp_idle) & ~fifo_empty;
   assign resp_data_active = reset_n_i & (resp_state_q == e_resp_data);
   assign resp_hdr_hs      = io_resp_header_v_i & io_resp_header_ready_and_o;
   assign resp_data_hs     = io_resp_data_v_i & io_resp_data_ready_and_o;

   assign io_resp_header_ready_and_o = resp_hdr_open & src_resp_header_ready_and_i[head_id];
   assign io_resp_data_ready_and_o   = resp_data_active & src_resp_data_ready_and_i[head_id];

   // Response payload is broadcast; only the head source's valid is raised.
   always_comb begin
      src_resp_header_v_o = '0;
      src_resp_data_v_o   = '0;
      for (int i = 0; i < num_src_p; i++) begin
         src_resp_header_o[i]   = io_resp_header_i;
         src_resp_has_data_o[i] = io_resp_has_data_i;
         src_resp_data_o[i]     = io_resp_data_i;
         src_resp_last_o[i]     = io_resp_last_i;
      end
      if (resp_hdr_open)    src_resp_header_v_o[head_id] = io_resp_header_v_i;
      if (resp_data_active) src_resp_data_v_o[head_id]   = io_resp_data_v_i;
   end

   // Response FSM: route stays at FIFO head until the whole message is delivered.
   always_comb begin
      resp_state_d = resp_state_q;
      unique case (resp_state_q)
         e_resp_idle: if (resp_hdr_hs && io_resp_has_data_i) resp_state_d = e_resp_data;
         e_resp_data: if (resp_data_hs && io_resp_last_i)    resp_state_d = e_resp_idle;
      endcase
   end

   assign fifo_push = cmd_hdr_hs;
   assign fifo_pop  = (resp_hdr_hs & ~io_resp_has_data_i) | (resp_data_hs & io_resp_last_i);

   bp_io_src_route_fifo #(
      .els_p   (max_outstanding_p),
      .width_p (src_id_width_lp)
   ) route_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (grant_id),
      .v_i       (fifo_push),
      .data_o    (head_id),
      .yumi_i    (fifo_pop),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (outstanding_o)
   );

   // State registers for both FSMs, pointer and lock.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cmd_state_q  <= e_cmd_idle;
         resp_state_q <= e_resp_idle;
         rr_q         <= '0;
         lock_q       <= '0;
      end else begin
         cmd_state_q  <= cmd_state_d;
         resp_state_q <= resp_state_d;
         rr_q         <= rr_d;
         lock_q       <= lock_d;
      end
   end

endmodule

// File: tb/tb_bp_io_cmd_merge.sv
// Scoreboard bench for bp_io_cmd_merge: directed traffic, queued expectations, negedge monitor.
`timescale 1ns/1ps
module tb_bp_io_cmd_merge;
   localparam int NS = 4, HW = 72, DW = 64, MO = 8;
   localparam int OW = $clog2(MO + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;

   logic [NS-1:0][HW-1:0] src_cmd_header;
   logic [NS-1:0]         src_cmd_header_v, src_cmd_header_ready_and, src_cmd_has_data;
   logic [NS-1:0][DW-1:0] src_cmd_data;
   logic [NS-1:0]         src_cmd_data_v, src_cmd_data_ready_and, src_cmd_last;
   logic [HW-1:0]         io_cmd_header;
   logic                  io_cmd_header_v, io_cmd_has_data, io_cmd_data_v, io_cmd_last;
   logic [DW-1:0]         io_cmd_data;
   logic                  io_cmd_header_ready_and, io_cmd_data_ready_and;
   logic [HW-1:0]         io_resp_header;
   logic                  io_resp_header_v, io_resp_has_data, io_resp_data_v, io_resp_last;
   logic [DW-1:0]         io_resp_data;
   logic                  io_resp_header_ready_and, io_resp_data_ready_and;
   logic [NS-1:0][HW-1:0] src_resp_header;
   logic [NS-1:0]         src_resp_header_v, src_resp_has_data, src_resp_data_v, src_resp_last;
   logic [NS-1:0][DW-1:0] src_resp_data;
   logic [NS-1:0]         src_resp_header_ready_and, src_resp_data_ready_and;
   logic [OW-1:0]         outstanding;

   bp_io_cmd_merge #(
      .num_src_p(NS), .header_width_p(HW), .data_width_p(DW), .max_outstanding_p(MO)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .src_cmd_header_i(src_cmd_header), .src_cmd_header_v_i(src_cmd_header_v),
      .src_cmd_header_ready_and_o(src_cmd_header_ready_and),
      .src_cmd_has_data_i(src_cmd_has_data), .src_cmd_data_i(src_cmd_data),
      .src_cmd_data_v_i(src_cmd_data_v), .src_cmd_data_ready_and_o(src_cmd_data_ready_and),
      .src_cmd_last_i(src_cmd_last),
      .io_cmd_header_o(io_cmd_header), .io_cmd_header_v_o(io_cmd_header_v),
      .io_cmd_has_data_o(io_cmd_has_data), .io_cmd_data_o(io_cmd_data),
      .io_cmd_data_v_o(io_cmd_data_v), .io_cmd_last_o(io_cmd_last),
      .io_cmd_header_ready_and_i(io_cmd_header_ready_and),
      .io_cmd_data_ready_and_i(io_cmd_data_ready_and),
      .io_resp_header_i(io_resp_header), .io_resp_header_v_i(io_resp_header_v),
      .io_resp_has_data_i(io_resp_has_data), .io_resp_data_i(io_resp_data),
      .io_resp_data_v_i(io_resp_data_v), .io_resp_last_i(io_resp_last),
      .io_resp_header_ready_and_o(io_resp_header_ready_and),
      .io_resp_data_ready_and_o(io_resp_data_ready_and),
      .src_resp_header_o(src_resp_header), .src_resp_header_v_o(src_resp_header_v),
      .src_resp_has_data_o(src_resp_has_data), .src_resp_data_o(src_resp_data),
      .src_resp_data_v_o(src_resp_data_v), .src_resp_last_o(src_resp_last),
      .src_resp_header_ready_and_i(src_resp_header_ready_and),
      .src_resp_data_ready_and_i(src_resp_data_ready_and),
      .outstanding_o(outstanding)
   );

   typedef struct { logic [HW-1:0] hdr; int nbeats; } msg_t;
   typedef struct { logic [DW-1:0] data; logic last; } beat_t;

   msg_t  cq [NS][$];          // per-source command stimulus
   int    cph [NS], cbeat [NS];
   msg_t  rq [$];              // response stimulus
   int    rph, rbeat;
   msg_t  exp_cmd [$];
   beat_t exp_beat [$];
   msg_t  exp_rsp [NS][$];
   beat_t exp_rbeat [NS][$];
   int    issue_cyc [$];
   int    last_beat_cyc, last_rsp_cyc;
   int    cyc = 0;
   int    total = 0, bad = 0;
   msg_t  mm;
   beat_t mb;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [HW-1:0] mk_hdr(input int s, input int tag);
      logic [HW-1:0] h;
      h = '0;
      h[15:8] = s[7:0];
      h[7:0]  = tag[7:0];
      return h;
   endfunction

   function automatic logic [DW-1:0] beat_val(input logic [HW-1:0] h, input int j);
      logic [DW-1:0] d;
      d = '0;
      d[15:0]  = h[15:0];
      d[23:16] = j[7:0];
      d[31:24] = 8'hbe;
      return d;
   endfunction

   task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name, input logic [HW-1:0] act);
      total++;
      bad++;
      $display("FAIL %s: got %0h with nothing expected", name, act);
   endtask

   task automatic send_cmd(input int s, input int tag, input int nb);
      msg_t m;
      m.hdr = mk_hdr(s, tag);
      m.nbeats = nb;
      cq[s].push_back(m);
   endtask

   task automatic expect_cmd(input int s, input int tag, input int nb);
      msg_t m;
      beat_t b;
      m.hdr = mk_hdr(s, tag);
      m.nbeats = nb;
      exp_cmd.push_back(m);
      for (int j = 0; j < nb; j++) begin
         b.data = beat_val(m.hdr, j);
         b.last = (j == nb - 1);
         exp_beat.push_back(b);
      end
   endtask

   // Issue a response and record which source must receive it.
   task automatic send_rsp(input int dst, input int tag, input int nb);
      msg_t m;
      beat_t b;
      m.hdr = mk_hdr(dst, tag);
      m.nbeats = nb;
      rq.push_back(m);
      exp_rsp[dst].push_back(m);
      for (int j = 0; j < nb; j++) begin
         b.data = beat_val(m.hdr, j);
         b.last = (j == nb - 1);
         exp_rbeat[dst].push_back(b);
      end
   endtask

   task automatic drive();
      for (int s = 0; s < NS; s++) begin
         src_cmd_header_v[s] = 1'b0;
         src_cmd_data_v[s]   = 1'b0;
         src_cmd_has_data[s] = 1'b0;
         src_cmd_last[s]     = 1'b0;
         if (cq[s].size() > 0) begin
            src_cmd_header[s]   = cq[s][0].hdr;
            src_cmd_has_data[s] = (cq[s][0].nbeats > 0);
            if (cph[s] == 0) src_cmd_header_v[s] = 1'b1;
            else begin
               src_cmd_data_v[s] = 1'b1;
               src_cmd_data[s]   = beat_val(cq[s][0].hdr, cbeat[s]);
               src_cmd_last[s]   = (cbeat[s] == cq[s][0].nbeats - 1);
            end
         end
      end
      io_resp_header_v = 1'b0;
      io_resp_data_v   = 1'b0;
      io_resp_has_data = 1'b0;
      io_resp_last     = 1'b0;
      if (rq.size() > 0) begin
         io_resp_header   = rq[0].hdr;
         io_resp_has_data = (rq[0].nbeats > 0);
         if (rph == 0) io_resp_header_v = 1'b1;
         else begin
            io_resp_data_v = 1'b1;
            io_resp_data   = beat_val(rq[0].hdr, rbeat);
            io_resp_last   = (rbeat == rq[0].nbeats - 1);
         end
      end
   endtask

   // One clock: sample handshakes at negedge, retire them after the posedge, re-drive.
   task automatic tick();
      logic [NS-1:0] hh, dh;
      logic rh, rd;
      @(negedge clk);
      hh = src_cmd_header_v & src_cmd_header_ready_and;
      dh = src_cmd_data_v & src_cmd_data_ready_and;
      rh = io_resp_header_v & io_resp_header_ready_and;
      rd = io_resp_data_v & io_resp_data_ready_and;
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
         if (cq[s].size() > 0) begin
            if (cph[s] == 0 && hh[s]) begin
               if (cq[s][0].nbeats > 0) begin cph[s] = 1; cbeat[s] = 0; end
               else void'(cq[s].pop_front());
            end else if (cph[s] == 1 && dh[s]) begin
               cbeat[s]++;
               if (cbeat[s] == cq[s][0].nbeats) begin cph[s] = 0; void'(cq[s].pop_front()); end
            end
         end
      end
      if (rq.size() > 0) begin
         if (rph == 0 && rh) begin
            if (rq[0].nbeats > 0) begin rph = 1; rbeat = 0; end
            else void'(rq.pop_front());
         end else if (rph == 1 && rd) begin
            rbeat++;
            if (rbeat == rq[0].nbeats) begin rph = 0; void'(rq.pop_front()); end
         end
      end
      drive();
   endtask

   function automatic bit busy();
      bit b;
      b = (rq.size() > 0) || (exp_cmd.size() > 0) || (exp_beat.size() > 0);
      for (int s = 0; s < NS; s++)
         b = b || (cq[s].size() > 0) || (exp_rsp[s].size() > 0) || (exp_rbeat[s].size() > 0);
      return b;
   endfunction

   task automatic wait_drain(input string name, input int limit);
      int n;
      n = 0;
      drive();
      while (busy() && n < limit) begin
         tick();
         n++;
      end
      if (busy()) begin
         total++;
         bad++;
         $display("FAIL %s: traffic still pending after %0d cycles, required drained", name, limit);
      end
   endtask

   // Monitor: compares every DUT-side handshake against the expectation queues.
   always @(negedge clk) begin
      if (reset_n) begin
         if (io_cmd_header_v && io_cmd_header_ready_and) begin
            issue_cyc.push_back(cyc);
            if (exp_cmd.size() == 0) unexp("cmd_hdr_unexp", io_cmd_header);
            else begin
               mm = exp_cmd.pop_front();
               chk("cmd_hdr", io_cmd_header, mm.hdr);
               chk("cmd_has_data", HW'(io_cmd_has_data), HW'(mm.nbeats > 0));
            end
         end
         if (io_cmd_data_v && io_cmd_data_ready_and) begin
            if (io_cmd_last) last_beat_cyc = cyc;
            if (exp_beat.size() == 0) unexp("cmd_beat_unexp", HW'(io_cmd_data));
            else begin
               mb = exp_beat.pop_front();
               chk("cmd_beat", HW'(io_cmd_data), HW'(mb.data));
               chk("cmd_last", HW'(io_cmd_last), HW'(mb.last));
            end
         end
         if (|src_resp_header_v) chk("rsp_onehot", HW'($countones(src_resp_header_v)), HW'(1));
         for (int s = 0; s < NS; s++) begin
            if (src_resp_header_v[s] && src_resp_header_ready_and[s]) begin
               last_rsp_cyc = cyc;
               if (exp_rsp[s].size() == 0) unexp("rsp_hdr_unexp", src_resp_header[s]);
               else begin
                  mm = exp_rsp[s].pop_front();
                  chk("rsp_hdr", src_resp_header[s], mm.hdr);
               end
            end
            if (src_resp_data_v[s] && src_resp_data_ready_and[s]) begin
               if (exp_rbeat[s].size() == 0) unexp("rsp_beat_unexp", HW'(src_resp_data[s]));
               else begin
                  mb = exp_rbeat[s].pop_front();
                  chk("rsp_beat", HW'(src_resp_data[s]), HW'(mb.data));
                  chk("rsp_last", HW'(src_resp_last[s]), HW'(mb.last));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ever;
      src_cmd_header = '0; src_cmd_data = '0; io_resp_header = '0; io_resp_data = '0;
      for (int s = 0; s < NS; s++) begin cph[s] = 0; cbeat[s] = 0; end
      rph = 0; rbeat = 0; last_beat_cyc = 0; last_rsp_cyc = 0;
      io_cmd_header_ready_and   = 1'b1;
      io_cmd_data_ready_and     = 1'b1;
      src_resp_header_ready_and = '1;
      src_resp_data_ready_and   = '1;
      reset_n = 1'b0;

      // All four sources request a header-only read while reset is still held.
      for (int s = 0; s < NS; s++) begin send_cmd(s, 16 + s, 0); expect_cmd(s, 16 + s, 0); end
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hdr_v", HW'(io_cmd_header_v), HW'(0));
      chk("rst_hdr_rdy", HW'(src_cmd_header_ready_and), HW'(0));
      chk("rst_resp_rdy", HW'(io_resp_header_ready_and), HW'(0));
      chk("rst_outstanding", HW'(outstanding), HW'(0));
      reset_n = 1'b1;
      issue_cyc.delete();
      repeat (5) tick();
      chk("a_outstanding", HW'(outstanding), HW'(4));
      chk("a_issued", HW'(issue_cyc.size()), HW'(4));
      if (issue_cyc.size() == 4) chk("a_consecutive", HW'(issue_cyc[3] - issue_cyc[0]), HW'(3));
      for (int s = 0; s < NS; s++) send_rsp(s, 32 + s, 0);
      wait_drain("a_drain", 50);
      chk("a_out_zero", HW'(outstanding), HW'(0));

      // Src 2 locks the link for four beats while src 0 waits.
      send_cmd(1, 'h20, 0); expect_cmd(1, 'h20, 0);
      wait_drain("b_pre", 20);
      send_cmd(2, 'h21, 4); send_cmd(0, 'h22, 0);
      expect_cmd(2, 'h21, 4); expect_cmd(0, 'h22, 0);
      issue_cyc.delete();
      wait_drain("b_lock", 40);
      chk("b_issued", HW'(issue_cyc.size()), HW'(2));
      if (issue_cyc.size() == 2) chk("b_src0_after_last", HW'(issue_cyc[1]), HW'(last_beat_cyc + 1));
      chk("b_outstanding", HW'(outstanding), HW'(3));
      send_rsp(1, 'h23, 0); send_rsp(2, 'h24, 0); send_rsp(0, 'h25, 0);
      wait_drain("b_drain", 40);
      chk("b_out_zero", HW'(outstanding), HW'(0));

      // Fill the route FIFO; the ninth header must wait for a pop plus one cycle.
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < NS; s++) send_cmd(s, 'h30 + r * 4 + s, 0);
      send_cmd(1, 'h38, 0);
      for (int r = 0; r < 2; r++) begin
         expect_cmd(1, 'h31 + r * 4, 0); expect_cmd(2, 'h32 + r * 4, 0);
         expect_cmd(3, 'h33 + r * 4, 0); expect_cmd(0, 'h30 + r * 4, 0);
      end
      expect_cmd(1, 'h38, 0);
      issue_cyc.delete();
      drive();
      repeat (12) tick();
      chk("d_full_count", HW'(outstanding), HW'(8));
      chk("d_issued", HW'(issue_cyc.size()), HW'(8));
      chk("d_hdr_v_blocked", HW'(io_cmd_header_v), HW'(0));
      issue_cyc.delete();
      send_rsp(1, 'h40, 0);
      drive();
      repeat (3) tick();
      chk("d_ninth_issued", HW'(issue_cyc.size()), HW'(1));
      if (issue_cyc.size() == 1) chk("d_ninth_next_cycle", HW'(issue_cyc[0]), HW'(last_rsp_cyc + 1));
      chk("d_still_full", HW'(outstanding), HW'(8));
      send_rsp(2, 'h42, 0); send_rsp(3, 'h43, 0); send_rsp(0, 'h44, 0); send_rsp(1, 'h45, 0);
      send_rsp(2, 'h46, 0); send_rsp(3, 'h47, 0); send_rsp(0, 'h48, 0); send_rsp(1, 'h49, 0);
      wait_drain("d_drain", 60);
      chk("d_out_zero", HW'(outstanding), HW'(0));

      // Responses to src 3 (header only) then src 1 (two beats).
      send_cmd(3, 'h50, 0); send_cmd(1, 'h51, 0);
      expect_cmd(3, 'h50, 0); expect_cmd(1, 'h51, 0);
      wait_drain("e_cmds", 20);
      chk("e_outstanding", HW'(outstanding), HW'(2));
      send_rsp(3, 'h52, 0); send_rsp(1, 'h53, 2);
      drive();
      tick(); chk("e_after_src3_hdr", HW'(outstanding), HW'(1));
      tick(); chk("e_after_src1_hdr", HW'(outstanding), HW'(1));
      tick(); chk("e_after_beat0", HW'(outstanding), HW'(1));
      tick(); chk("e_after_last", HW'(outstanding), HW'(0));
      wait_drain("e_drain", 10);

      // A response with nothing outstanding is never accepted.
      mm.hdr = mk_hdr(0, 'h60);
      mm.nbeats = 0;
      rq.push_back(mm);
      drive();
      ever = 1'b0;
      repeat (20) begin
         tick();
         if (io_resp_header_ready_and || (|src_resp_header_v)) ever = 1'b1;
      end
      chk("f_never_ready", HW'(ever), HW'(0));
      chk("f_outstanding", HW'(outstanding), HW'(0));
      rq.delete();
      rph = 0;
      drive();

      // Reset in the middle of a data message with three commands outstanding.
      send_cmd(2, 'h70, 0); send_cmd(3, 'h71, 0); send_cmd(0, 'h72, 4);
      expect_cmd(2, 'h70, 0); expect_cmd(3, 'h71, 0); expect_cmd(0, 'h72, 4);
      drive();
      repeat (4) tick();
      chk("g_outstanding", HW'(outstanding), HW'(3));
      chk("g_in_data", HW'(io_cmd_data_v), HW'(1));
      reset_n = 1'b0;
      #1;
      chk("g_rst_data_v", HW'(io_cmd_data_v), HW'(0));
      chk("g_rst_hdr_v", HW'(io_cmd_header_v), HW'(0));
      chk("g_rst_readies", HW'({src_cmd_header_ready_and, src_cmd_data_ready_and,
                                io_resp_header_ready_and, io_resp_data_ready_and}), HW'(0));
      chk("g_rst_outstanding", HW'(outstanding), HW'(0));
      for (int s = 0; s < NS; s++) begin cq[s].delete(); cph[s] = 0; end
      exp_cmd.delete();
      exp_beat.delete();
      drive();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      send_cmd(1, 'h80, 0); send_cmd(0, 'h81, 0);
      expect_cmd(0, 'h81, 0); expect_cmd(1, 'h80, 0);
      issue_cyc.delete();
      wait_drain("g_restart", 20);
      chk("g_restart_issued", HW'(issue_cyc.size()), HW'(2));
      chk("g_restart_out", HW'(outstanding), HW'(2));

      chk("end_idle", HW'(busy()), HW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bp_io_cmd_merge.md
Name: bp_io_cmd_merge

Overview:
- Merges the outgoing BedRock I/O command streams of num_src_p unicores into one I/O port.
- Routes each I/O response back to the core that issued the matching command.
- Successor to the flat per-core I/O fan-out: generalised source count, round-robin arbitration, multi-beat message locking and in-order response routing with an outstanding-request limit.
- Sits between the core complex and the single host I/O link.

Parameters:
- num_src_p, 4, number of source cores (≥1; 1 degenerates to pass-through plus route tracking)
- header_width_p, 72, BedRock mem header width
- data_width_p, 64, data beat width
- max_outstanding_p, 8, route FIFO depth = max in-flight commands (power of two, ≥2)
- src_id_width_lp, `BSG_SAFE_CLOG2(num_src_p), derived

Ports:
- clk_i in 1 clock
- reset_n_i in 1 asynchronous active-low reset
- src_cmd_header_i in [num_src_p][header_width_p] per-core command header
- src_cmd_header_v_i in [num_src_p] header valid
- src_cmd_header_ready_and_o out [num_src_p] header ready
- src_cmd_has_data_i in [num_src_p] message carries data beats
- src_cmd_data_i in [num_src_p][data_width_p] data beat
- src_cmd_data_v_i in [num_src_p] data valid
- src_cmd_data_ready_and_o out [num_src_p] data ready
- src_cmd_last_i in [num_src_p] final data beat
- io_cmd_header_o/_v_o/_has_data_o/_data_o/_data_v_o/_last_o out merged command, widths as per-source
- io_cmd_header_ready_and_i, io_cmd_data_ready_and_i in 1 each, downstream ready
- io_resp_header_i/_v_i/_has_data_i/_data_i/_data_v_i/_last_i in merged response
- io_resp_header_ready_and_o, io_resp_data_ready_and_o out 1 each
- src_resp_header_o/_v_o/_has_data_o/_data_o/_data_v_o/_last_o out [num_src_p] per-core response
- src_resp_header_ready_and_i, src_resp_data_ready_and_i in [num_src_p]
- outstanding_o out [`BSG_WIDTH(max_outstanding_p)] in-flight count

Behaviour:
- Reset (reset_n_i low, async): cmd FSM e_cmd_idle, resp FSM e_resp_idle, rr pointer 0, route FIFO empty, outstanding_o 0; every v_o and ready_and_o 0 while asserted.
- Cmd FSM e_cmd_idle: grant = first valid source at or after rr pointer (wrapping); grant is a function of v_i and pointer only, never of ready.
  - io_cmd_header_v_o = grant exists AND route FIFO not full; header/has_data forwarded combinationally (0-cycle latency).
  - Only the granted source sees header ready; handshake pushes its id into the route FIFO; pointer ← grant+1 mod num_src_p.
  - has_data=1 → e_cmd_data, locked to the granted source; has_data=0 → stay in e_cmd_idle.
- e_cmd_data: data beats pass combinationally from the locked source only; header channel blocked (all header ready 0, header_v_o 0). Handshake with last=1 → e_cmd_idle.
- Route FIFO full: header_v_o held 0, all sources stalled. A pop in the same cycle does not unblock the push; push resumes next cycle.
- Resp FSM e_resp_idle: io_resp_header_ready_and_o = FIFO not empty AND the head source's header ready. Header is forwarded to the head source only.
  - Header handshake with has_data=0 pops the FIFO.
  - Header handshake with has_data=1 → e_resp_data.
- e_resp_data: beats go to the head source; last-beat handshake pops the FIFO → e_resp_idle.
- Route FIFO empty: response ready 0 (a response with no outstanding command is never accepted).
- outstanding_o: +1 on push, −1 on pop, unchanged on simultaneous push and pop; never exceeds max_outstanding_p.
- Ordering: responses are assumed in command order (host link is in-order); routing is strictly FIFO.

Decomposition:
- Shared package bp_io_merge_pkg:
  - bp_io_cmd_state_e {e_cmd_idle, e_cmd_data}
  - bp_io_resp_state_e {e_resp_idle, e_resp_data}
- Sub-module bp_io_src_route_fifo: 1r1w, depth max_outstanding_p, width src_id_width_lp, full/empty/count outputs, async active-low reset.

Test Plan:
- All 4 sources assert a header-only read simultaneously, downstream always ready → issued in order src 0,1,2,3 on 4 consecutive cycles; FIFO holds 0,1,2,3; outstanding_o=4.
- Src 2 sends a header with has_data=1 and 4 beats while src 0 is valid → no src 0 header until src 2's last beat handshakes; src 0 issues on the following cycle.
- Issue 8 commands with no responses → 9th header_v_o held 0; one header-only response pops → 9th issues the next cycle, not the same cycle.
- Responses for sources 3,1 (second carries 2 data beats) → header to src 3, then header plus 2 beats to src 1; outstanding_o decrements after src 3's header and after src 1's last beat.
- Response while FIFO empty → io_resp_header_ready_and_o stays 0 for 20 cycles; nothing is delivered.
- Drop reset_n_i mid-transfer (cmd in e_cmd_data, 3 outstanding) → all valids/readies 0 immediately; after release outstanding_o=0 and arbitration starts at src 0.
